// File: rtl/byte_to_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_to_word_packer
// Brief    : Packs an 8-bit valid/ready byte stream into registered 16-bit
//            words; s_last forces emission of a padded partial word.
//            Optional word/partial counters: BYTE_TO_WORD_PACKER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module byte_to_word_packer #(
    parameter bit         MSB_FIRST = 1'b1,
    parameter logic [7:0] PAD_BYTE  = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_data,
    output logic        m_partial
`ifdef BYTE_TO_WORD_PACKER_STATS_EN
    ,
    input  logic        stats_clr,
    output logic [31:0] words_out,
    output logic [15:0] partial_out
`endif
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_hold;
    logic        r_m_valid;
    logic [15:0] r_m_data;
    logic        r_m_partial;

    logic        w_accept;
    logic        w_emit;
    logic        w_partial;
    logic        w_load_hold;
    logic [15:0] w_word;

    // Ready depends only on registered state and m_ready, never on s_valid.
    assign s_ready   = rst_n && (!r_m_valid || m_ready);
    assign w_accept  = s_valid && s_ready;

    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign m_partial = r_m_partial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_partial   = 1'b0;
        w_load_hold = 1'b0;
        w_word      = r_m_data;
        if (w_accept) begin
            case (r_state)
                ST_EMPTY: begin
                    if (s_last) begin
                        w_emit    = 1'b1;
                        w_partial = 1'b1;
                        w_word    = MSB_FIRST ? {s_data, PAD_BYTE} : {PAD_BYTE, s_data};
                    end else begin
                        w_load_hold = 1'b1;
                        w_state_nxt = ST_HALF;
                    end
                end
                ST_HALF: begin
                    w_emit      = 1'b1;
                    w_word      = MSB_FIRST ? {r_hold, s_data} : {s_data, r_hold};
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= 8'h00;
        end else if (w_load_hold) begin
            r_hold <= s_data;
        end
    end

    // A new word overwrites one transferring on the same edge, so no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid   <= 1'b0;
            r_m_data    <= 16'h0000;
            r_m_partial <= 1'b0;
        end else if (w_emit) begin
            r_m_valid   <= 1'b1;
            r_m_data    <= w_word;
            r_m_partial <= w_partial;
        end else if (m_ready) begin
            r_m_valid   <= 1'b0;
        end
    end

`ifdef BYTE_TO_WORD_PACKER_STATS_EN
    logic        w_xfer;
    logic [31:0] r_words;
    logic [15:0] r_partials;

    assign w_xfer      = r_m_valid && m_ready;
    assign words_out   = r_words;
    assign partial_out = r_partials;

    // Clear has priority over a coincident transfer; counters saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_words    <= 32'd0;
            r_partials <= 16'd0;
        end else if (stats_clr) begin
            r_words    <= 32'd0;
            r_partials <= 16'd0;
        end else if (w_xfer) begin
            if (r_words != 32'hFFFF_FFFF) begin
                r_words <= r_words + 32'd1;
            end
            if (r_m_partial && (r_partials != 16'hFFFF)) begin
                r_partials <= r_partials + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_byte_to_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_to_word_packer
// Brief    : Directed self-checking bench; one MSB-first instance with zero
//            pad and one LSB-first instance with pad 8'hEE share the stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_byte_to_word_packer;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        m_ready;

    logic        s_ready_a,   s_ready_b;
    logic        m_valid_a,   m_valid_b;
    logic [15:0] m_data_a,    m_data_b;
    logic        m_partial_a, m_partial_b;

    int checks;
    int failures;

`ifdef BYTE_TO_WORD_PACKER_STATS_EN
    logic        stats_clr;
    logic [31:0] words_a,   words_b;
    logic [15:0] partial_a, partial_b;
`endif

    byte_to_word_packer #(.MSB_FIRST(1'b1), .PAD_BYTE(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready_a),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid_a),
        .m_ready   (m_ready),
        .m_data    (m_data_a),
        .m_partial (m_partial_a)
`ifdef BYTE_TO_WORD_PACKER_STATS_EN
        ,
        .stats_clr   (stats_clr),
        .words_out   (words_a),
        .partial_out (partial_a)
`endif
    );

    byte_to_word_packer #(.MSB_FIRST(1'b0), .PAD_BYTE(8'hEE)) dut_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready_b),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid_b),
        .m_ready   (m_ready),
        .m_data    (m_data_b),
        .m_partial (m_partial_b)
`ifdef BYTE_TO_WORD_PACKER_STATS_EN
        ,
        .stats_clr   (stats_clr),
        .words_out   (words_b),
        .partial_out (partial_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks both instances' output word state in one call.
    task automatic chk_out(input string tag, input logic v, input logic [15:0] da,
                           input logic [15:0] db, input logic p);
        chk({tag, ".valid_a"}, {31'd0, m_valid_a}, {31'd0, v});
        chk({tag, ".valid_b"}, {31'd0, m_valid_b}, {31'd0, v});
        if (v) begin
            chk({tag, ".data_a"}, {16'd0, m_data_a}, {16'd0, da});
            chk({tag, ".data_b"}, {16'd0, m_data_b}, {16'd0, db});
            chk({tag, ".part_a"}, {31'd0, m_partial_a}, {31'd0, p});
            chk({tag, ".part_b"}, {31'd0, m_partial_b}, {31'd0, p});
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l);
        s_valid = v;
        s_data  = d;
        s_last  = l;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        m_ready  = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
`ifdef BYTE_TO_WORD_PACKER_STATS_EN
        stats_clr = 1'b0;
`endif
        cyc();
        cyc();

        // Reset state
        chk("rst.valid", {31'd0, m_valid_a}, 32'd0);
        chk("rst.data", {16'd0, m_data_a}, 32'd0);
        chk("rst.partial", {31'd0, m_partial_b}, 32'd0);
        chk("rst.s_ready", {31'd0, s_ready_a}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst.s_ready", {31'd0, s_ready_a}, 32'd1);

        // Full-word stream, 1 word per 2 clocks
        drive(1'b1, 8'hA1, 1'b0); cyc(); chk_out("t1.b0", 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1'b1, 8'hB2, 1'b0); cyc(); chk_out("t1.w0", 1'b1, 16'hA1B2, 16'hB2A1, 1'b0);
        drive(1'b1, 8'hC3, 1'b0); cyc(); chk_out("t1.b2", 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1'b1, 8'hD4, 1'b0); cyc(); chk_out("t1.w1", 1'b1, 16'hC3D4, 16'hD4C3, 1'b0);
        drive(1'b0, 8'h00, 1'b0); cyc(); chk_out("t1.idle", 1'b0, 16'h0, 16'h0, 1'b0);

        // Single-byte frame from EMPTY -> padded partial word
        drive(1'b1, 8'h5A, 1'b1); cyc(); chk_out("t2.part", 1'b1, 16'h5A00, 16'hEE5A, 1'b1);
        drive(1'b0, 8'h00, 1'b0); cyc(); chk_out("t2.idle", 1'b0, 16'h0, 16'h0, 1'b0);

        // Backpressure with a held word, then release
        drive(1'b1, 8'h11, 1'b0); cyc();
        drive(1'b1, 8'h22, 1'b0); cyc(); chk_out("t3.w0", 1'b1, 16'h1122, 16'h2211, 1'b0);
        m_ready = 1'b0;
        drive(1'b1, 8'h33, 1'b0);
        #1;
        chk("t3.bp.s_ready", {31'd0, s_ready_a}, 32'd0);
        cyc(); chk_out("t3.hold1", 1'b1, 16'h1122, 16'h2211, 1'b0);
        cyc(); chk_out("t3.hold2", 1'b1, 16'h1122, 16'h2211, 1'b0);
        m_ready = 1'b1;
        #1;
        chk("t3.rel.s_ready", {31'd0, s_ready_a}, 32'd1);
        cyc(); chk_out("t3.xfer", 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1'b1, 8'h44, 1'b0); cyc(); chk_out("t3.w1", 1'b1, 16'h3344, 16'h4433, 1'b0);
        // Completing byte accepted on the same edge the word transfers
        drive(1'b1, 8'h55, 1'b1); cyc(); chk_out("t3.b2b", 1'b1, 16'h5500, 16'hEE55, 1'b1);
        drive(1'b0, 8'h00, 1'b0); cyc(); chk_out("t3.idle", 1'b0, 16'h0, 16'h0, 1'b0);

        // Reset mid-frame discards the held byte
        drive(1'b1, 8'h77, 1'b0); cyc();
        drive(1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t4.rst.valid", {31'd0, m_valid_a}, 32'd0);
        chk("t4.rst.s_ready", {31'd0, s_ready_a}, 32'd0);
        cyc();
        rst_n = 1'b1;
        drive(1'b1, 8'h88, 1'b0); cyc(); chk_out("t4.b0", 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1'b1, 8'h99, 1'b0); cyc(); chk_out("t4.w0", 1'b1, 16'h8899, 16'h9988, 1'b0);

`ifdef BYTE_TO_WORD_PACKER_STATS_EN
        // Clear coincides with the 8899 transfer: clear wins
        drive(1'b0, 8'h00, 1'b0);
        stats_clr = 1'b1;
        cyc();
        stats_clr = 1'b0;
        chk("st.clr_wins.words", words_a, 32'd0);
        chk("st.clr_wins.part", {16'd0, partial_a}, 32'd0);
        drive(1'b1, 8'h01, 1'b0); cyc();
        drive(1'b1, 8'h02, 1'b0); cyc();
        drive(1'b1, 8'h03, 1'b0); cyc();
        drive(1'b1, 8'h04, 1'b0); cyc();
        drive(1'b1, 8'h05, 1'b0); cyc();
        drive(1'b1, 8'h06, 1'b0); cyc();
        drive(1'b1, 8'h07, 1'b1); cyc();
        drive(1'b0, 8'h00, 1'b0); cyc();
        chk("st.words", words_a, 32'd4);
        chk("st.part", {16'd0, partial_a}, 32'd1);
        chk("st.words_b", words_b, 32'd4);
        stats_clr = 1'b1;
        cyc();
        stats_clr = 1'b0;
        chk("st.clr.words", words_a, 32'd0);
        chk("st.clr.part", {16'd0, partial_a}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
